sig_filt_nch: RTL and testbench
===============================

SIG_FILT_NCH -- requirements
Module: sig_filt_nch

Interface
REQ-001 Parameter NCH, default 2: number of independent input channels (1..16).
REQ-002 Parameter CNT_W, default 16: stability counter and threshold width.
REQ-003 Parameter PER_W, default 16: period counter width.
REQ-004 Parameter FAST_SIM, default 0: when 1, the effective threshold SHALL be min(thresh, 511).
REQ-005 Port clk, input, 1 bit: single clock; all logic SHALL be on posedge clk.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port sig_in, input, NCH bits: raw asynchronous inputs (cadence, brake, switches).
REQ-008 Port thresh, input, CNT_W bits: stable-cycle threshold shared by all channels; quasi-static.
REQ-009 Port sig_filt, output, NCH bits: debounced, synchronised level.
REQ-010 Port rise, output, NCH bits: one-cycle pulse on each sig_filt 0->1 transition.
REQ-011 Port fall, output, NCH bits: one-cycle pulse on each sig_filt 1->0 transition.
REQ-012 Port period, output, NCH*PER_W bits: channel i is period[i*PER_W +: PER_W], the cycles between successive rises.
REQ-013 Port period_vld, output, NCH bits: one-cycle pulse when the period of channel i updates.
REQ-014 Port stopped, output, NCH bits: channel has no rise within 2^PER_W-1 cycles.

Function
REQ-015 Each channel SHALL pass sig_in[i] through stg1, stg2 and stg3 registers; stg1 and stg2 are the metastability synchroniser.
REQ-016 Stability counter: cleared to 0 when stg2!=stg3, else incremented, saturating at all-ones (no wrap).
REQ-017 sig_filt[i] SHALL load stg3 on any edge where the registered counter >= effective threshold, else hold.
REQ-018 Latency: a raw change held stable SHALL appear on sig_filt exactly thresh+4 cycles later; thresh=0 gives 4 cycles with no debounce.
REQ-019 Any input pulse shorter than thresh+1 cycles at stg3 SHALL NOT change sig_filt.
REQ-020 A thresh change SHALL take effect on the next comparison without clearing counters.
REQ-021 rise/fall SHALL be registered and asserted on the same edge that sig_filt changes, high for exactly one cycle.
REQ-022 Period counter per channel: cleared to 0 on an edge where rise is set, else incremented, saturating at 2^PER_W-1.
REQ-023 On rise with stopped=0: period <= counter+1 and period_vld pulses one cycle.
REQ-024 On rise with stopped=1: stopped SHALL clear; period and period_vld are unchanged (no valid reference edge).
REQ-025 When the counter reaches 2^PER_W-1: stopped SHALL set and period SHALL be forced to all-ones, with no period_vld.
REQ-026 Rise and saturation on the same cycle: rise SHALL win.
REQ-027 Channels SHALL be fully independent; simultaneous events on different channels do not interact.

Reset
REQ-028 rst_n low SHALL asynchronously clear stg1/2/3, all counters, sig_filt, rise, fall, period and period_vld to 0, and set stopped to all-ones.
REQ-029 Reset asserted mid-operation SHALL abort all in-progress filtering and measurement; nothing resumes after release.

Structure
REQ-030 Package sig_filt_pkg SHALL hold the default NCH/CNT_W/PER_W constants and the FAST_SIM threshold cap (511).
REQ-031 All per-channel logic SHALL live in sub-module sig_filt_chan, instantiated NCH times by a generate loop; the top holds only the effective-threshold computation and port packing.

Verification
REQ-032 thresh=10, ch0 steps 0->1 and holds -> sig_filt[0]=1 and rise[0] pulse exactly 14 cycles later; fall[0] stays 0.
REQ-033 thresh=10, ch0 glitches high for 8 cycles -> sig_filt[0] stays 0 with no rise; then a 12-cycle pulse -> a rise follows.
REQ-034 thresh=2, ch1 square wave period 40 -> first rise clears stopped[1]; second rise gives period=40 and one period_vld[1] pulse; repeats each cycle of the wave.
REQ-035 PER_W=8, ch0 held low after a rise -> stopped[0]=1 and period=255 exactly 255 cycles after that rise; the next rise gives no period_vld.
REQ-036 rst_n pulsed low mid-count on both channels -> all outputs 0 and stopped=all-ones immediately, with no pulses after release.
REQ-037 FAST_SIM=1, thresh=1000 -> latency is 515 cycles.

Source files
------------

// File: rtl/sig_filt_pkg.sv
// Shared defaults for the multi-channel debounce / period filter.
package sig_filt_pkg;

    localparam int unsigned NCH_DEF      = 2;
    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned PER_W_DEF    = 16;
    localparam int unsigned FAST_SIM_CAP = 511;

endpackage

// File: rtl/sig_filt_chan.sv
// One channel: 3-stage sync, stability-count debounce, edge pulses and period/stop tracking.
module sig_filt_chan
    import sig_filt_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] thresh,
    output logic             sig_filt,
    output logic             rise,
    output logic             fall,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             stopped
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [PER_W-1:0] PerMax = '1;

    logic             stg1_q, stg2_q, stg3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d, fall_q, fall_d;
    logic [PER_W-1:0] pcnt_q, pcnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             vld_q, vld_d;
    logic             stop_q, stop_d;

    always_comb begin
        cnt_d    = (stg2_q != stg3_q) ? '0 : ((cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1);
        filt_d   = (cnt_q >= thresh) ? stg3_q : filt_q;
        rise_d   = filt_d & ~filt_q;
        fall_d   = ~filt_d & filt_q;
        pcnt_d   = rise_d ? '0 : ((pcnt_q == PerMax) ? pcnt_q : pcnt_q + 1'b1);
        period_d = period_q;
        vld_d    = 1'b0;
        stop_d   = stop_q;
        // A rise after a stop has no valid reference edge, so it only re-arms.
        if (rise_d) begin
            if (stop_q) begin
                stop_d = 1'b0;
            end else begin
                period_d = pcnt_q + 1'b1;
                vld_d    = 1'b1;
            end
        end else if (pcnt_d == PerMax) begin
            stop_d   = 1'b1;
            period_d = PerMax;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg1_q   <= 1'b0;
            stg2_q   <= 1'b0;
            stg3_q   <= 1'b0;
            cnt_q    <= '0;
            filt_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            pcnt_q   <= '0;
            period_q <= '0;
            vld_q    <= 1'b0;
            stop_q   <= 1'b1;
        end else begin
            stg1_q   <= sig_in;
            stg2_q   <= stg1_q;
            stg3_q   <= stg2_q;
            cnt_q    <= cnt_d;
            filt_q   <= filt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            stop_q   <= stop_d;
        end
    end

    assign sig_filt   = filt_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign period     = period_q;
    assign period_vld = vld_q;
    assign stopped    = stop_q;

endmodule

// File: rtl/sig_filt_nch.sv
// NCH independent debounce channels sharing one (optionally capped) stability threshold.
module sig_filt_nch
    import sig_filt_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned PER_W    = PER_W_DEF,
    parameter int unsigned FAST_SIM = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       sig_in,
    input  logic [CNT_W-1:0]     thresh,
    output logic [NCH-1:0]       sig_filt,
    output logic [NCH-1:0]       rise,
    output logic [NCH-1:0]       fall,
    output logic [NCH*PER_W-1:0] period,
    output logic [NCH-1:0]       period_vld,
    output logic [NCH-1:0]       stopped
);

    // Narrow counters can never exceed the cap, so the clamp only exists when it can bite.
    localparam bit CapActive = (FAST_SIM != 0) && (CNT_W > 9);

    logic [CNT_W-1:0] eff_thresh;

    always_comb begin
        eff_thresh = thresh;
        if (CapActive && (thresh > CNT_W'(FAST_SIM_CAP))) begin
            eff_thresh = CNT_W'(FAST_SIM_CAP);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        sig_filt_chan #(
            .CNT_W (CNT_W),
            .PER_W (PER_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .sig_in     (sig_in[i]),
            .thresh     (eff_thresh),
            .sig_filt   (sig_filt[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .period     (period[i*PER_W +: PER_W]),
            .period_vld (period_vld[i]),
            .stopped    (stopped[i])
        );
    end

endmodule

// File: tb/tb_sig_filt_nch.sv
// Directed bench: latency/glitch table on ch0, then period, saturation, fast-sim and reset sequences.
module tb_sig_filt_nch;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sig_in, sig_in_b;
    logic [15:0] thresh, thresh_b;
    logic [1:0]  sig_filt, rise, fall, period_vld, stopped;
    logic [31:0] period;
    logic [1:0]  sig_filt_b, rise_b, fall_b, period_vld_b, stopped_b;
    logic [15:0] period_b;

    sig_filt_nch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .thresh     (thresh),
        .sig_filt   (sig_filt),
        .rise       (rise),
        .fall       (fall),
        .period     (period),
        .period_vld (period_vld),
        .stopped    (stopped)
    );

    sig_filt_nch #(
        .NCH      (2),
        .CNT_W    (16),
        .PER_W    (8),
        .FAST_SIM (1)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in_b),
        .thresh     (thresh_b),
        .sig_filt   (sig_filt_b),
        .rise       (rise_b),
        .fall       (fall_b),
        .period     (period_b),
        .period_vld (period_vld_b),
        .stopped    (stopped_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int unsigned thr;
        int unsigned len;  // 0 = hold high for the whole window
        int unsigned lat;  // 0 = no rise expected
    } vec_t;

    vec_t vecs [9];

    initial begin
        int unsigned lat, lat2, nrise, nfall, nvld, rr, act;

        vecs[0] = '{10, 0, 14};
        vecs[1] = '{10, 8, 0};
        vecs[2] = '{10, 12, 14};
        vecs[3] = '{0, 0, 4};
        vecs[4] = '{2, 0, 6};
        vecs[5] = '{5, 5, 0};
        vecs[6] = '{5, 6, 9};
        vecs[7] = '{3, 1, 0};
        vecs[8] = '{0, 1, 4};

        rst_n = 1'b1; sig_in = '0; sig_in_b = '0; thresh = 16'd10; thresh_b = 16'd2;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sig_filt", sig_filt, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_period", period, 0);
        check("rst_period_vld", period_vld, 0);
        check("rst_stopped", stopped, 2'b11);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Latency / glitch-rejection table on ch0
        for (int v = 0; v < 9; v++) begin
            thresh = 16'(vecs[v].thr);
            lat = 0; nrise = 0; nfall = 0;
            sig_in[0] = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                step();
                if (rise[0]) begin
                    nrise++;
                    if (lat == 0) lat = c;
                end
                if (fall[0]) nfall++;
                if (c == int'(vecs[v].len)) sig_in[0] = 1'b0;
            end
            sig_in[0] = 1'b0;
            check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
            check($sformatf("vec%0d_rise_cycles", v), nrise, (vecs[v].lat != 0) ? 1 : 0);
            check($sformatf("vec%0d_fall_cycles", v), nfall,
                  (vecs[v].len != 0 && vecs[v].lat != 0) ? 1 : 0);
            repeat (40) step();
            check($sformatf("vec%0d_idle", v), sig_filt[0], 0);
        end

        // Square wave, period 40, on ch1
        thresh = 16'd2;
        sig_in[1] = 1'b1;
        nrise = 0; nfall = 0; nvld = 0; act = 0;
        for (int c = 1; c <= 170; c++) begin
            step();
            if (rise[1]) begin
                check($sformatf("sq_rise%0d_cycle", nrise), c, 6 + 40 * nrise);
                if (nrise == 0) begin
                    check("sq_first_stopped", stopped[1], 0);
                    check("sq_first_no_vld", period_vld[1], 0);
                end
                nrise++;
            end
            if (period_vld[1]) begin
                nvld++;
                check("sq_period", period[31:16], 40);
            end
            if (fall[1]) nfall++;
            if (rise[0] || fall[0] || sig_filt[0] || period_vld[0]) act++;
            sig_in[1] = ((c % 40) < 20);
        end
        check("sq_rise_count", nrise, 5);
        check("sq_vld_count", nvld, 4);
        check("sq_fall_count", nfall, 4);
        check("sq_ch0_quiet", act, 0);
        sig_in[1] = 1'b0;
        repeat (40) step();

        // Period saturation with PER_W=8 on dut_b ch0
        sig_in_b[0] = 1'b1;
        rr = 0; nvld = 0;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (rise_b[0] && rr == 0) rr = c;
            if (period_vld_b[0]) nvld++;
            if (c == 20) sig_in_b[0] = 1'b0;
            if (rr != 0 && c == int'(rr) + 254) check("sat_not_yet", stopped_b[0], 0);
            if (rr != 0 && c == int'(rr) + 255) begin
                check("sat_stopped", stopped_b[0], 1);
                check("sat_period", period_b[7:0], 255);
            end
        end
        check("sat_rise_cycle", rr, 6);
        check("sat_no_vld", nvld, 0);

        // Rise after stop only re-arms; the following rise measures 50
        sig_in_b[0] = 1'b1;
        nvld = 0;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (c == 6) begin
                check("rearm_rise", rise_b[0], 1);
                check("rearm_no_vld", period_vld_b[0], 0);
                check("rearm_stopped", stopped_b[0], 0);
            end
            if (period_vld_b[0]) begin
                nvld++;
                check("rearm_vld_cycle", c, 56);
                check("rearm_period", period_b[7:0], 50);
            end
            if (c == 20) sig_in_b[0] = 1'b0;
            if (c == 50) sig_in_b[0] = 1'b1;
        end
        check("rearm_vld_count", nvld, 1);

        // Threshold 1000: capped to 511 with FAST_SIM, full value otherwise
        thresh = 16'd1000; thresh_b = 16'd1000;
        sig_in[0] = 1'b1; sig_in_b[1] = 1'b1;
        lat = 0; lat2 = 0;
        for (int c = 1; c <= 1100; c++) begin
            step();
            if (rise_b[1] && lat == 0) lat = c;
            if (rise[0] && lat2 == 0) lat2 = c;
        end
        check("fastsim_latency", lat, 515);
        check("full_thresh_latency", lat2, 1004);

        // Reset mid-count on both channels
        thresh = 16'd10;
        sig_in = 2'b10;
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_sig_filt", sig_filt, 0);
        check("mid_rst_rise", rise, 0);
        check("mid_rst_fall", fall, 0);
        check("mid_rst_period", period, 0);
        check("mid_rst_vld", period_vld, 0);
        check("mid_rst_stopped", stopped, 2'b11);
        check("mid_rst_stopped_b", stopped_b, 2'b11);
        sig_in = '0; sig_in_b = '0;
        repeat (2) step();
        rst_n = 1'b1;
        act = 0;
        for (int c = 1; c <= 60; c++) begin
            step();
            if ((rise | fall | period_vld | sig_filt) != 0) act++;
            if ((rise_b | fall_b | period_vld_b | sig_filt_b) != 0) act++;
        end
        check("post_rst_quiet", act, 0);
        check("post_rst_stopped", stopped, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
